uart_rx_fifo: RTL and testbench

Receive buffer directly downstream of the UART receiver. Drains each received byte through the receiver's rx_valid/rx_read handshake into a DEPTH-entry synchronous FIFO. Presents a show-ahead pop interface, level and status flags, and an overrun tracker to the AXI4-Lite register slave. Lets software tolerate read latency of many byte times without losing data.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_fifo_mem.sv | 26 ++
 rtl/uart_rx_fifo.sv | 111 +++++++++++
 tb/tb_uart_rx_fifo.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the receive-path blocks.
package uart_pkg;

    localparam int unsigned UART_DATA_W        = 8;
    localparam int unsigned UART_RX_FIFO_DEPTH = 16;
    localparam int unsigned UART_OVR_CNT_W     = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte register array: synchronous write, asynchronous (show-ahead) read.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  uart_byte_t       i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output uart_byte_t       o_rdata
);

    uart_byte_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer: drains the UART receiver handshake into a byte FIFO with
// show-ahead pop, level/threshold flags and a sticky saturating overrun tracker.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [UART_DATA_W-1:0]    rx_data,
    input  logic                      rx_valid,
    output logic                      rx_read,
    input  logic                      pop,
    output logic [UART_DATA_W-1:0]    pop_data,
    output logic                      empty,
    output logic                      full,
    output logic [AW:0]               level,
    input  logic [AW:0]               irq_thresh,
    output logic                      irq,
    output logic                      overrun,
    output logic [UART_OVR_CNT_W-1:0] overrun_cnt,
    input  logic                      overrun_clr,
    input  logic                      flush
);

    logic                      r_rx_read;
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [AW:0]               r_level;
    logic                      r_overrun;
    logic [UART_OVR_CNT_W-1:0] r_ovr_cnt;

    logic w_cap;
    logic w_empty;
    logic w_full;
    logic w_pop_eff;
    logic w_wr_eff;
    logic w_drop_full;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == (AW+1)'(DEPTH));

    // The acknowledge cycle masks the still-high rx_valid so a byte is taken once.
    assign w_cap       = rx_valid & ~r_rx_read;
    assign w_pop_eff   = pop & ~w_empty & ~flush;
    assign w_wr_eff    = w_cap & (~w_full | w_pop_eff) & ~flush;
    assign w_drop_full = w_cap & ~flush & w_full & ~w_pop_eff;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_read <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
        end else begin
            r_rx_read <= w_cap;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_wr_eff) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop_eff) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_level <= r_level + (AW+1)'(w_wr_eff) - (AW+1)'(w_pop_eff);
            end
        end
    end

    // A drop in the same cycle as a clear wins and restarts the count at one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overrun <= 1'b0;
            r_ovr_cnt <= '0;
        end else if (w_drop_full) begin
            r_overrun <= 1'b1;
            if (overrun_clr) begin
                r_ovr_cnt <= UART_OVR_CNT_W'(1);
            end else if (r_ovr_cnt != '1) begin
                r_ovr_cnt <= r_ovr_cnt + UART_OVR_CNT_W'(1);
            end
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
            r_ovr_cnt <= '0;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_eff),
        .i_waddr (r_wr_ptr),
        .i_wdata (rx_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (pop_data)
    );

    assign rx_read     = r_rx_read;
    assign empty       = w_empty;
    assign full        = w_full;
    assign level       = r_level;
    assign irq         = (irq_thresh != '0) && (r_level >= irq_thresh);
    assign overrun     = r_overrun;
    assign overrun_cnt = r_ovr_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: receiver handshake, ordering, overrun, irq, flush, reset.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_read;
    logic       pop;
    logic [7:0] pop_data;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic [4:0] irq_thresh;
    logic       irq;
    logic       overrun;
    logic [7:0] overrun_cnt;
    logic       overrun_clr;
    logic       flush;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] sb [$];
    int unsigned m_ovr = 0;

    uart_rx_fifo #(
        .DEPTH (16)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_read     (rx_read),
        .pop         (pop),
        .pop_data    (pop_data),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .irq_thresh  (irq_thresh),
        .irq         (irq),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt),
        .overrun_clr (overrun_clr),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte, waits (bounded) for the acknowledge, updates the model.
    task automatic send_byte(input logic [7:0] d);
        int unsigned n = 0;
        rx_data  = d;
        rx_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!rx_read && n < 8);
        checks++;
        if (rx_read !== 1'b1) begin
            errors++;
            $display("FAIL send_ack byte=%02h rx_read=%b exp=1", d, rx_read);
        end
        rx_valid = 1'b0;
        if (sb.size() < 16) sb.push_back(d);
        else if (m_ovr < 255) m_ovr++;
    endtask

    task automatic do_pop(output logic [7:0] got);
        got = pop_data;
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (rx_read !== 1'b0)      begin errors++; $display("FAIL reset_rx_read got=%b exp=0", rx_read); end
        checks++; if (level !== 5'd0)        begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (empty !== 1'b1)        begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0)         begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (irq !== 1'b0)          begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (overrun !== 1'b0)      begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (overrun_cnt !== 8'd0)  begin errors++; $display("FAIL reset_ovr_cnt got=%0d exp=0", overrun_cnt); end
    endtask

    task automatic test_single();
        logic [7:0] got;
        logic [7:0] exp;
        send_byte(8'hA5);
        checks++; if (level !== 5'd1)     begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
        checks++; if (empty !== 1'b0)     begin errors++; $display("FAIL single_empty got=%b exp=0", empty); end
        checks++; if (pop_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%02h exp=a5", pop_data); end
        tick();
        checks++; if (rx_read !== 1'b0)   begin errors++; $display("FAIL single_ack_width got=%b exp=0", rx_read); end
        do_pop(got);
        exp = sb.pop_front();
        checks++; if (got !== exp)        begin errors++; $display("FAIL single_pop got=%02h exp=%02h", got, exp); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL single_empty_after got=%b exp=1", empty); end
        checks++; if (level !== 5'd0)     begin errors++; $display("FAIL single_level_after got=%0d exp=0", level); end
    endtask

    task automatic test_fill();
        logic [7:0] got;
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        checks++; if (full !== 1'b1)   begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_level got=%0d exp=16", level); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fill_overrun got=%b exp=0", overrun); end
        for (int i = 0; i < 16; i++) begin
            do_pop(got);
            exp = sb.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL fill_order idx=%0d got=%02h exp=%02h", i, got, exp); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drained got=%b exp=1", empty); end
        send_byte(8'h55);
        do_pop(got);
        exp = sb.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL fill_wrap got=%02h exp=%02h", got, exp); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
        for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i));
        checks++; if (overrun !== 1'b1)              begin errors++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        checks++; if (overrun_cnt !== 8'(m_ovr))     begin errors++; $display("FAIL ovr_cnt got=%0d exp=%0d", overrun_cnt, m_ovr); end
        checks++; if (level !== 5'd16)               begin errors++; $display("FAIL ovr_level got=%0d exp=16", level); end
        checks++; if (pop_data !== sb[0])            begin errors++; $display("FAIL ovr_head got=%02h exp=%02h", pop_data, sb[0]); end
        tick();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        m_ovr = 0;
        checks++; if (overrun !== 1'b0)     begin errors++; $display("FAIL ovr_clr_flag got=%b exp=0", overrun); end
        checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL ovr_clr_cnt got=%0d exp=0", overrun_cnt); end
        rx_data     = 8'hE3;
        rx_valid    = 1'b1;
        overrun_clr = 1'b1;
        tick();
        rx_valid    = 1'b0;
        overrun_clr = 1'b0;
        m_ovr = 1;
        checks++; if (rx_read !== 1'b1)          begin errors++; $display("FAIL ovr_set_ack got=%b exp=1", rx_read); end
        checks++; if (overrun !== 1'b1)          begin errors++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
        checks++; if (overrun_cnt !== 8'(m_ovr)) begin errors++; $display("FAIL ovr_set_cnt got=%0d exp=%0d", overrun_cnt, m_ovr); end
        tick();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        m_ovr = 0;
    endtask

    task automatic test_simultaneous();
        logic [7:0] got;
        logic [7:0] exp;
        tick();
        rx_data  = 8'h99;
        rx_valid = 1'b1;
        got      = pop_data;
        pop      = 1'b1;
        tick();
        pop      = 1'b0;
        rx_valid = 1'b0;
        exp = sb.pop_front();
        sb.push_back(8'h99);
        checks++; if (got !== exp)       begin errors++; $display("FAIL sim_full_pop got=%02h exp=%02h", got, exp); end
        checks++; if (rx_read !== 1'b1)  begin errors++; $display("FAIL sim_full_ack got=%b exp=1", rx_read); end
        checks++; if (level !== 5'd16)   begin errors++; $display("FAIL sim_full_level got=%0d exp=16", level); end
        checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL sim_full_overrun got=%b exp=0", overrun); end
        while (sb.size() > 0) begin
            do_pop(got);
            exp = sb.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL sim_drain got=%02h exp=%02h", got, exp); end
        end
        send_byte(8'h31);
        tick();
        rx_data  = 8'h32;
        rx_valid = 1'b1;
        got      = pop_data;
        pop      = 1'b1;
        tick();
        pop      = 1'b0;
        rx_valid = 1'b0;
        exp = sb.pop_front();
        sb.push_back(8'h32);
        checks++; if (got !== exp)     begin errors++; $display("FAIL sim_l1_pop got=%02h exp=%02h", got, exp); end
        checks++; if (level !== 5'd1)  begin errors++; $display("FAIL sim_l1_level got=%0d exp=1", level); end
        do_pop(got);
        exp = sb.pop_front();
        checks++; if (got !== exp)     begin errors++; $display("FAIL sim_l1_new got=%02h exp=%02h", got, exp); end
    endtask

    task automatic test_thresh();
        logic [7:0] got;
        logic [7:0] exp;
        irq_thresh = 5'd4;
        for (int i = 0; i < 3; i++) send_byte(8'h61 + 8'(i));
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_below got=%b exp=0", irq); end
        send_byte(8'h64);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_at got=%b exp=1", irq); end
        do_pop(got);
        exp = sb.pop_front();
        checks++; if (got !== exp)  begin errors++; $display("FAIL irq_pop got=%02h exp=%02h", got, exp); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_pop got=%b exp=0", irq); end
        irq_thresh = 5'd0;
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled got=%b exp=0", irq); end
    endtask

    task automatic test_flush();
        logic [7:0] got;
        logic [7:0] exp;
        send_byte(8'h71);
        send_byte(8'h72);
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL flush_pre_level got=%0d exp=5", level); end
        tick();
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        flush    = 1'b1;
        tick();
        rx_valid = 1'b0;
        flush    = 1'b0;
        sb.delete();
        checks++; if (rx_read !== 1'b1)          begin errors++; $display("FAIL flush_ack got=%b exp=1", rx_read); end
        checks++; if (level !== 5'd0)            begin errors++; $display("FAIL flush_level got=%0d exp=0", level); end
        checks++; if (empty !== 1'b1)            begin errors++; $display("FAIL flush_empty got=%b exp=1", empty); end
        checks++; if (overrun !== 1'b0)          begin errors++; $display("FAIL flush_overrun got=%b exp=0", overrun); end
        checks++; if (overrun_cnt !== 8'(m_ovr)) begin errors++; $display("FAIL flush_ovr_cnt got=%0d exp=%0d", overrun_cnt, m_ovr); end
        send_byte(8'h42);
        do_pop(got);
        exp = sb.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL flush_reuse got=%02h exp=%02h", got, exp); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        logic [7:0] exp;
        irq_thresh = 5'd1;
        send_byte(8'h81);
        send_byte(8'h82);
        rx_data  = 8'h83;
        rx_valid = 1'b1;
        #2;
        resetn   = 1'b0;
        rx_valid = 1'b0;
        #1;
        checks++; if (rx_read !== 1'b0)     begin errors++; $display("FAIL rst_mid_rx_read got=%b exp=0", rx_read); end
        checks++; if (level !== 5'd0)       begin errors++; $display("FAIL rst_mid_level got=%0d exp=0", level); end
        checks++; if (empty !== 1'b1)       begin errors++; $display("FAIL rst_mid_empty got=%b exp=1", empty); end
        checks++; if (irq !== 1'b0)         begin errors++; $display("FAIL rst_mid_irq got=%b exp=0", irq); end
        checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL rst_mid_ovr_cnt got=%0d exp=0", overrun_cnt); end
        tick();
        resetn = 1'b1;
        sb.delete();
        m_ovr = 0;
        irq_thresh = 5'd0;
        tick();
        send_byte(8'h3C);
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL rst_after_level got=%0d exp=1", level); end
        do_pop(got);
        exp = sb.pop_front();
        checks++; if (got !== exp)    begin errors++; $display("FAIL rst_after_data got=%02h exp=%02h", got, exp); end
    endtask

    initial begin
        resetn      = 1'b0;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        pop         = 1'b0;
        irq_thresh  = 5'd0;
        overrun_clr = 1'b0;
        flush       = 1'b0;
        tick();
        tick();
        test_reset();
        resetn = 1'b1;
        tick();
        test_single();
        test_fill();
        test_overrun();
        test_simultaneous();
        test_thresh();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
